// File: rtl/cpu_step_pkg.sv
// ============================================================================
// Module      : cpu_step_pkg
// Description : Shared state encodings for the CPU run/halt/step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_step_pkg;

  // Sequencer states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

endpackage : cpu_step_pkg

`default_nettype wire

// File: rtl/wrap_cnt.sv
// ============================================================================
// Module      : wrap_cnt
// Description : Free-wrapping counter with increment enable and a clear
//               that takes priority over the increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrap_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc_i, wrapping naturally at 2^CNT_W; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule : wrap_cnt

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Run/halt/step sequencer for the single-cycle RISC-V core.
//               Produces cpu_en_o (one high cycle = one retired instruction),
//               handles halt/run/step-N commands, stalls on memory not-ready
//               and keeps cycle/instret counters.
//               Optional macro STEP_CTRL_BP_EN enables a PC breakpoint that
//               traps before the instruction at bp_addr_i executes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int STEP_W    = 8,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_halt_i,
  input  logic              cmd_run_i,
  input  logic              cmd_step_i,
  input  logic [STEP_W-1:0] step_n_i,
  input  logic              mem_ready_i,
  input  logic [31:0]       pc_in_i,
  input  logic              bp_en_i,
  input  logic [31:0]       bp_addr_i,
  input  logic              cnt_clr_i,
  output logic              cpu_en_o,
  output logic              halted_o,
  output logic              bp_hit_o,
  output logic [1:0]        state_o,
  output logic [STEP_W-1:0] step_left_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  instret_cnt_o
);

  localparam state_e c_RST_STATE = RESET_RUN ? ST_RUN : ST_HALT;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_left_q, step_left_d;
  logic              bp_skip_q, bp_skip_d;

  logic              w_active;
  logic              w_brk_now;
  logic              w_retire;
  logic [STEP_W-1:0] w_step_load;

  assign w_active = (state_q == ST_RUN) || (state_q == ST_STEP);

`ifdef STEP_CTRL_BP_EN
  // Break before execute; bp_skip lets the trapped PC run once after resume.
  assign w_brk_now = bp_en_i && (pc_in_i == bp_addr_i) && !bp_skip_q && w_active;
`else
  assign w_brk_now = 1'b0;
  wire w_unused_bp = &{1'b0, bp_en_i, bp_addr_i, bp_skip_q};
`endif

  // rst gating keeps the datapath frozen even when reset parks us in RUN.
  assign w_retire    = w_active && mem_ready_i && !w_brk_now && !rst;
  assign w_step_load = (step_n_i == '0) ? STEP_W'(1) : step_n_i;

  // State, remaining-step and breakpoint-skip registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_RST_STATE;
      step_left_q <= '0;
      bp_skip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_left_q <= step_left_d;
      bp_skip_q   <= bp_skip_d;
    end
  end

  // Next-state: halt > step > run; breakpoint only interrupts RUN/STEP.
  always_comb begin
    state_d     = state_q;
    step_left_d = step_left_q;
    bp_skip_d   = w_retire ? 1'b0 : bp_skip_q;
    case (state_q)
      ST_HALT, ST_BRK: begin
        if (cmd_halt_i) begin
          state_d = state_q;
        end else if (cmd_step_i) begin
          state_d     = ST_STEP;
          step_left_d = w_step_load;
          bp_skip_d   = (state_q == ST_BRK);
        end else if (cmd_run_i) begin
          state_d   = ST_RUN;
          bp_skip_d = (state_q == ST_BRK);
        end
      end
      ST_RUN: begin
        if (cmd_halt_i) begin
          state_d = ST_HALT;
        end else if (w_brk_now) begin
          state_d = ST_BRK;
        end
      end
      ST_STEP: begin
        if (cmd_halt_i) begin
          state_d     = ST_HALT;
          step_left_d = '0;
        end else if (cmd_run_i) begin
          state_d     = ST_RUN;
          step_left_d = '0;
        end else if (w_brk_now) begin
          state_d     = ST_BRK;
          step_left_d = '0;
        end else if (w_retire) begin
          if (step_left_q == STEP_W'(1)) begin
            state_d     = ST_HALT;
            step_left_d = '0;
          end else begin
            step_left_d = step_left_q - STEP_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_HALT;
        step_left_d = '0;
      end
    endcase
  end

  wrap_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (1'b1),
    .clr_i (cnt_clr_i),
    .cnt_o (cycle_cnt_o)
  );

  wrap_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_retire),
    .clr_i (cnt_clr_i),
    .cnt_o (instret_cnt_o)
  );

  assign cpu_en_o    = w_retire;
  assign halted_o    = (state_q == ST_HALT) || (state_q == ST_BRK);
  assign bp_hit_o    = (state_q == ST_BRK);
  assign state_o     = state_q;
  assign step_left_o = step_left_q;

endmodule : cpu_step_ctrl

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Self-checking bench for cpu_step_ctrl. Directed commands push
//               expected retire records; a monitor pops one per cpu_en cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_halt, cmd_run, cmd_step, mem_ready, bp_en, cnt_clr;
  logic [7:0]  step_n;
  logic [31:0] pc, bp_addr;
  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [7:0]  step_left;
  logic [31:0] cycle_cnt, instret_cnt;

  localparam logic [1:0] HALT = 2'b00, RUN = 2'b01, STEP = 2'b10, BRK = 2'b11;

  typedef struct {
    logic [1:0]  st;
    logic [7:0]  sl;
    logic        chk_pc;
    logic [31:0] pc;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cpu_step_ctrl #(.CNT_W(32), .STEP_W(8), .RESET_RUN(1'b0)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_halt_i    (cmd_halt),
    .cmd_run_i     (cmd_run),
    .cmd_step_i    (cmd_step),
    .step_n_i      (step_n),
    .mem_ready_i   (mem_ready),
    .pc_in_i       (pc),
    .bp_en_i       (bp_en),
    .bp_addr_i     (bp_addr),
    .cnt_clr_i     (cnt_clr),
    .cpu_en_o      (cpu_en),
    .halted_o      (halted),
    .bp_hit_o      (bp_hit),
    .state_o       (state),
    .step_left_o   (step_left),
    .cycle_cnt_o   (cycle_cnt),
    .instret_cnt_o (instret_cnt)
  );

  always #5 clk = ~clk;

  // Minimal datapath stand-in: PC advances by 4 on every retire.
  always @(posedge clk or posedge rst) begin
    if (rst)         pc <= 32'h0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [7:0] sl, input logic cp, input logic [31:0] p);
    rec_t r;
    r.st = st; r.sl = sl; r.chk_pc = cp; r.pc = p;
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every retire cycle must match the next expected record.
  always @(negedge clk) begin
    if (cpu_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: state %0d step_left %0d pc 0x%0h, none expected", state, step_left, pc);
      end else begin
        rec_t r;
        r = sb.pop_front();
        chk("retire_state", 32'(state), 32'(r.st));
        chk("retire_step_left", 32'(step_left), 32'(r.sl));
        if (r.chk_pc) chk("retire_pc", pc, r.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_halt = 0; cmd_run = 0; cmd_step = 0; step_n = 0;
    mem_ready = 1; bp_en = 0; bp_addr = 0; cnt_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(HALT));
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_halted", 32'(halted), 1);
    rst = 1'b0;

    // Idle in HALT: cycles count, nothing retires.
    repeat (5) tick();
    chk("idle_cycle", cycle_cnt, 5);
    chk("idle_instret", instret_cnt, 0);
    chk("idle_cpu_en", 32'(cpu_en), 0);

    // Step 3.
    push(STEP, 3, 0, 0); push(STEP, 2, 0, 0); push(STEP, 1, 0, 0);
    cmd_step = 1; step_n = 3; tick(); cmd_step = 0;
    chk("step3_state", 32'(state), 32'(STEP));
    chk("step3_left", 32'(step_left), 3);
    repeat (5) tick();
    chk("step3_done_state", 32'(state), 32'(HALT));
    chk("step3_done_left", 32'(step_left), 0);
    chk("step3_instret", instret_cnt, 3);

    // Step 5 with a 4-cycle memory stall after the second retire.
    for (int i = 5; i >= 1; i--) push(STEP, 8'(i), 0, 0);
    cmd_step = 1; step_n = 5; tick(); cmd_step = 0;
    tick(); tick();
    mem_ready = 0;
    repeat (4) tick();
    chk("stall_left", 32'(step_left), 3);
    chk("stall_state", 32'(state), 32'(STEP));
    chk("stall_cpu_en", 32'(cpu_en), 0);
    mem_ready = 1;
    repeat (5) tick();
    chk("step5_state", 32'(state), 32'(HALT));
    chk("step5_instret", instret_cnt, 8);

    // RUN, then halt+run together: halt wins, that cycle still retires.
    for (int i = 0; i < 3; i++) push(RUN, 0, 0, 0);
    cmd_run = 1; tick(); cmd_run = 0;
    chk("run_state", 32'(state), 32'(RUN));
    repeat (2) tick();
    cmd_halt = 1; cmd_run = 1; tick(); cmd_halt = 0; cmd_run = 0;
    chk("halt_wins_state", 32'(state), 32'(HALT));
    chk("halt_wins_cpu_en", 32'(cpu_en), 0);
    chk("halt_wins_instret", instret_cnt, 11);

    // step_n = 0 behaves as a single step.
    push(STEP, 1, 0, 0);
    cmd_step = 1; step_n = 0; tick(); cmd_step = 0;
    chk("step0_left", 32'(step_left), 1);
    repeat (3) tick();
    chk("step0_state", 32'(state), 32'(HALT));
    chk("step0_instret", instret_cnt, 12);

    // Counter clear while running.
    for (int i = 0; i < 4; i++) push(RUN, 0, 0, 0);
    cmd_run = 1; tick(); cmd_run = 0;
    tick();
    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("clr_cycle", cycle_cnt, 0);
    chk("clr_instret", instret_cnt, 0);
    tick();
    chk("clr_cycle_next", cycle_cnt, 1);
    chk("clr_instret_next", instret_cnt, 1);
    cmd_halt = 1; tick(); cmd_halt = 0;
    chk("clr_halt_state", 32'(state), 32'(HALT));
    chk("clr_halt_instret", instret_cnt, 2);

    // Reset in the middle of a 10-step run.
    push(STEP, 10, 0, 0); push(STEP, 9, 0, 0);
    cmd_step = 1; step_n = 10; tick(); cmd_step = 0;
    tick(); tick();
    rst = 1; #1;
    chk("midrst_state", 32'(state), 32'(HALT));
    chk("midrst_left", 32'(step_left), 0);
    chk("midrst_cycle", cycle_cnt, 0);
    chk("midrst_instret", instret_cnt, 0);
    chk("midrst_cpu_en", 32'(cpu_en), 0);
    tick(); rst = 0; tick();
    chk("postrst_state", 32'(state), 32'(HALT));
    chk("postrst_left", 32'(step_left), 0);

    // Breakpoint at 0x10 while running from PC 0.
    bp_addr = 32'h10; bp_en = 1;
`ifdef STEP_CTRL_BP_EN
    for (int i = 0; i < 4; i++) push(RUN, 0, 1, 32'(4 * i));
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (4) tick();
    chk("bp_pre_cpu_en", 32'(cpu_en), 0);
    tick();
    chk("bp_state", 32'(state), 32'(BRK));
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_halted", 32'(halted), 1);
    chk("bp_pc", pc, 32'h10);
    chk("bp_instret", instret_cnt, 4);
    push(RUN, 0, 1, 32'h10); push(RUN, 0, 1, 32'h14); push(RUN, 0, 1, 32'h18);
    cmd_run = 1; tick(); cmd_run = 0;
    chk("bp_resume_state", 32'(state), 32'(RUN));
    repeat (2) tick();
    cmd_halt = 1; tick(); cmd_halt = 0;
    chk("bp_end_state", 32'(state), 32'(HALT));
    chk("bp_end_instret", instret_cnt, 7);
`else
    for (int i = 0; i < 6; i++) push(RUN, 0, 1, 32'(4 * i));
    cmd_run = 1; tick(); cmd_run = 0;
    repeat (5) tick();
    chk("nobp_state", 32'(state), 32'(RUN));
    chk("nobp_hit", 32'(bp_hit), 0);
    chk("nobp_pc", pc, 32'h14);
    cmd_halt = 1; tick(); cmd_halt = 0;
    chk("nobp_end_state", 32'(state), 32'(HALT));
    chk("nobp_end_instret", instret_cnt, 6);
`endif

    repeat (2) tick();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_step_ctrl

`default_nettype wire
